// File: rtl/led_blink_sequencer_if.sv
// Control/config and LED-status bundle for the blink-burst sequencer.
// `repeat` is a reserved word, so the repeat request is carried as repeat_en.
interface led_blink_sequencer_if #(
   parameter int unsigned NUM_W = 4,
   parameter int unsigned PH_W  = 8
);
   logic             start;
   logic             stop;
   logic [NUM_W-1:0] blink_num;
   logic [PH_W-1:0]  on_ticks;
   logic [PH_W-1:0]  off_ticks;
   logic [PH_W-1:0]  gap_ticks;
   logic             repeat_en;
   logic             led;
   logic             busy;
   logic             done;

   modport master (
      output start, stop, blink_num, on_ticks, off_ticks, gap_ticks, repeat_en,
      input  led, busy, done
   );

   modport slave (
      input  start, stop, blink_num, on_ticks, off_ticks, gap_ticks, repeat_en,
      output led, busy, done
   );
endinterface

// File: rtl/led_blink_sequencer.sv
// Blink-burst controller: shared tick prescaler, per-phase tick counter and an
// ON/OFF/GAP FSM driving an active-low LED with a start/busy/done handshake.
module led_blink_sequencer #(
   parameter int unsigned TICK_DIV = 25_000,
   parameter int unsigned DIV_W    = 25,
   parameter int unsigned NUM_W    = 4,
   parameter int unsigned PH_W     = 8
) (
   input logic                  Clk50M,
   input logic                  Rst_n,
   led_blink_sequencer_if.slave bus
);

   typedef enum logic [1:0] {StIdle, StOn, StOff, StGap} state_e;

   state_e           state_q;
   logic [DIV_W-1:0] div_cnt_q;
   logic [PH_W-1:0]  phase_cnt_q;
   logic [NUM_W-1:0] blink_cnt_q;
   logic [NUM_W-1:0] num_q;
   logic [PH_W-1:0]  on_q;
   logic [PH_W-1:0]  off_q;
   logic [PH_W-1:0]  gap_q;
   logic             rpt_q;
   logic             led_q;
   logic             busy_q;
   logic             done_q;

   logic tick;
   logic start_ok;

   assign tick     = (div_cnt_q == DIV_W'(TICK_DIV - 1));
   assign start_ok = bus.start && (bus.blink_num != '0) && (bus.on_ticks != '0) &&
                     (bus.off_ticks != '0);

   assign bus.led  = led_q;
   assign bus.busy = busy_q;
   assign bus.done = done_q;

   always_ff @(posedge Clk50M or negedge Rst_n) begin
      if (!Rst_n) begin
         state_q     <= StIdle;
         div_cnt_q   <= '0;
         phase_cnt_q <= '0;
         blink_cnt_q <= '0;
         num_q       <= '0;
         on_q        <= '0;
         off_q       <= '0;
         gap_q       <= '0;
         rpt_q       <= 1'b0;
         led_q       <= 1'b1;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (bus.stop) begin
            // Abort wins over everything, including a same-cycle start in IDLE.
            state_q     <= StIdle;
            div_cnt_q   <= '0;
            phase_cnt_q <= '0;
            blink_cnt_q <= '0;
            led_q       <= 1'b1;
            busy_q      <= 1'b0;
         end else begin
            if (state_q == StIdle) begin
               div_cnt_q <= '0;
            end else begin
               div_cnt_q <= tick ? '0 : div_cnt_q + DIV_W'(1);
            end
            unique case (state_q)
               StIdle: begin
                  if (start_ok) begin
                     num_q       <= bus.blink_num;
                     on_q        <= bus.on_ticks;
                     off_q       <= bus.off_ticks;
                     gap_q       <= bus.gap_ticks;
                     rpt_q       <= bus.repeat_en;
                     phase_cnt_q <= '0;
                     blink_cnt_q <= '0;
                     state_q     <= StOn;
                     led_q       <= 1'b0;
                     busy_q      <= 1'b1;
                  end
               end
               StOn: begin
                  if (tick) begin
                     if (phase_cnt_q == on_q - PH_W'(1)) begin
                        phase_cnt_q <= '0;
                        state_q     <= StOff;
                        led_q       <= 1'b1;
                     end else begin
                        phase_cnt_q <= phase_cnt_q + PH_W'(1);
                     end
                  end
               end
               StOff: begin
                  if (tick) begin
                     if (phase_cnt_q == off_q - PH_W'(1)) begin
                        phase_cnt_q <= '0;
                        if (blink_cnt_q + NUM_W'(1) < num_q) begin
                           blink_cnt_q <= blink_cnt_q + NUM_W'(1);
                           state_q     <= StOn;
                           led_q       <= 1'b0;
                        end else begin
                           blink_cnt_q <= '0;
                           if (!rpt_q) begin
                              state_q <= StIdle;
                              busy_q  <= 1'b0;
                              done_q  <= 1'b1;
                           end else if (gap_q != '0) begin
                              state_q <= StGap;
                           end else begin
                              state_q <= StOn;
                              led_q   <= 1'b0;
                           end
                        end
                     end else begin
                        phase_cnt_q <= phase_cnt_q + PH_W'(1);
                     end
                  end
               end
               StGap: begin
                  if (tick) begin
                     if (phase_cnt_q == gap_q - PH_W'(1)) begin
                        phase_cnt_q <= '0;
                        state_q     <= StOn;
                        led_q       <= 1'b0;
                     end else begin
                        phase_cnt_q <= phase_cnt_q + PH_W'(1);
                     end
                  end
               end
               default: state_q <= StIdle;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_led_blink_sequencer.sv
// Bench for led_blink_sequencer: arithmetic timeline model checked every cycle,
// plus literal expectations for the directed scenarios.
module tb_led_blink_sequencer;

   localparam int unsigned TD = 4;

   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_err;

   led_blink_sequencer_if #(.NUM_W(4), .PH_W(8)) bus ();

   led_blink_sequencer #(
      .TICK_DIV (TD),
      .DIV_W    (3),
      .NUM_W    (4),
      .PH_W     (8)
   ) dut (
      .Clk50M (clk),
      .Rst_n  (rst_n),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, want %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model: time elapsed since the accepting edge, mapped onto the burst timeline.
   logic m_active;
   logic m_done;
   int   m_t;
   int   m_num, m_on, m_off, m_gap;
   logic m_rpt;

   function automatic int burst_len();
      return m_num * (m_on + m_off) * TD;
   endfunction

   function automatic logic exp_led();
      int b, p;
      if (!m_active) return 1'b1;
      b = burst_len();
      p = m_rpt ? (m_t % (b + m_gap * TD)) : m_t;
      if (p >= b) return 1'b1;
      return !((p % ((m_on + m_off) * TD)) < m_on * TD);
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_active <= 1'b0;
         m_done   <= 1'b0;
         m_t      <= 0;
      end else begin
         m_done <= 1'b0;
         if (bus.stop) begin
            m_active <= 1'b0;
            m_t      <= 0;
         end else if (!m_active) begin
            if (bus.start && bus.blink_num != 0 && bus.on_ticks != 0 && bus.off_ticks != 0) begin
               m_num    <= int'(bus.blink_num);
               m_on     <= int'(bus.on_ticks);
               m_off    <= int'(bus.off_ticks);
               m_gap    <= int'(bus.gap_ticks);
               m_rpt    <= bus.repeat_en;
               m_active <= 1'b1;
               m_t      <= 0;
            end
         end else if (!m_rpt && (m_t + 1 == burst_len())) begin
            m_active <= 1'b0;
            m_done   <= 1'b1;
         end else begin
            m_t <= m_t + 1;
         end
      end
   end

   always @(negedge clk) begin
      check("model_led", {31'd0, bus.led}, {31'd0, exp_led()});
      check("model_busy", {31'd0, bus.busy}, {31'd0, m_active});
      check("model_done", {31'd0, bus.done}, {31'd0, m_done});
   end

   task automatic step(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   // Returns at the sample point of the first cycle after the accepting edge.
   task automatic do_start(input int num, input int on, input int off, input int gap,
                           input logic rpt);
      bus.blink_num = 4'(num);
      bus.on_ticks  = 8'(on);
      bus.off_ticks = 8'(off);
      bus.gap_ticks = 8'(gap);
      bus.repeat_en = rpt;
      bus.start     = 1'b1;
      step(1);
      bus.start     = 1'b0;
   endtask

   logic led_a  [0:43];
   logic busy_a [0:43];
   logic done_a [0:43];

   initial begin
      int busy_cnt;
      int done_cnt;
      n_cmp = 0;
      n_err = 0;
      rst_n = 1'b0;
      bus.start = 1'b0;
      bus.stop = 1'b0;
      bus.blink_num = '0;
      bus.on_ticks = '0;
      bus.off_ticks = '0;
      bus.gap_ticks = '0;
      bus.repeat_en = 1'b0;
      step(3);
      check("reset_led", {31'd0, bus.led}, 32'd1);
      check("reset_busy", {31'd0, bus.busy}, 32'd0);
      check("reset_done", {31'd0, bus.done}, 32'd0);
      rst_n = 1'b1;
      step(2);

      // Normal burst: 12 low / 8 high / 12 low / 8 high, done at 40.
      do_start(2, 3, 2, 0, 1'b0);
      for (int k = 0; k < 44; k++) begin
         led_a[k]  = bus.led;
         busy_a[k] = bus.busy;
         done_a[k] = bus.done;
         step(1);
      end
      busy_cnt = 0;
      done_cnt = 0;
      for (int k = 0; k < 44; k++) begin
         busy_cnt += int'(busy_a[k]);
         done_cnt += int'(done_a[k]);
      end
      check("burst_led_0", {31'd0, led_a[0]}, 32'd0);
      check("burst_led_11", {31'd0, led_a[11]}, 32'd0);
      check("burst_led_12", {31'd0, led_a[12]}, 32'd1);
      check("burst_led_19", {31'd0, led_a[19]}, 32'd1);
      check("burst_led_20", {31'd0, led_a[20]}, 32'd0);
      check("burst_led_31", {31'd0, led_a[31]}, 32'd0);
      check("burst_led_32", {31'd0, led_a[32]}, 32'd1);
      check("burst_led_43", {31'd0, led_a[43]}, 32'd1);
      check("burst_done_40", {31'd0, done_a[40]}, 32'd1);
      check("burst_done_count", done_cnt, 32'd1);
      check("burst_busy_count", busy_cnt, 32'd40);
      check("burst_busy_39", {31'd0, busy_a[39]}, 32'd1);

      // Start while busy and on_ticks change mid-burst: timing unchanged.
      do_start(2, 3, 2, 0, 1'b0);
      step(5);
      bus.on_ticks = 8'd7;
      bus.start = 1'b1;
      step(1);
      bus.start = 1'b0;
      step(5);
      check("cfg_led_11", {31'd0, bus.led}, 32'd0);
      step(1);
      check("cfg_led_12", {31'd0, bus.led}, 32'd1);
      step(28);
      check("cfg_done_40", {31'd0, bus.done}, 32'd1);
      step(2);
      do_start(1, 7, 2, 0, 1'b0);
      step(27);
      check("cfg7_led_27", {31'd0, bus.led}, 32'd0);
      step(1);
      check("cfg7_led_28", {31'd0, bus.led}, 32'd1);
      step(8);
      check("cfg7_done_36", {31'd0, bus.done}, 32'd1);
      step(2);

      // Invalid requests.
      do_start(0, 3, 2, 0, 1'b0);
      step(2);
      check("inv_num_busy", {31'd0, bus.busy}, 32'd0);
      check("inv_num_led", {31'd0, bus.led}, 32'd1);
      do_start(2, 0, 2, 0, 1'b0);
      step(2);
      check("inv_on_busy", {31'd0, bus.busy}, 32'd0);
      bus.stop = 1'b1;
      do_start(2, 3, 2, 0, 1'b0);
      bus.stop = 1'b0;
      step(2);
      check("inv_stop_busy", {31'd0, bus.busy}, 32'd0);
      check("inv_stop_led", {31'd0, bus.led}, 32'd1);

      // Repeat with gap: 4 low / 12 high, period 16; stop mid-ON.
      do_start(1, 1, 1, 2, 1'b1);
      step(3);
      check("rg_led_3", {31'd0, bus.led}, 32'd0);
      step(1);
      check("rg_led_4", {31'd0, bus.led}, 32'd1);
      step(11);
      check("rg_led_15", {31'd0, bus.led}, 32'd1);
      step(1);
      check("rg_led_16", {31'd0, bus.led}, 32'd0);
      step(17);
      check("rg_led_33", {31'd0, bus.led}, 32'd0);
      bus.stop = 1'b1;
      step(1);
      bus.stop = 1'b0;
      check("rg_stop_led", {31'd0, bus.led}, 32'd1);
      check("rg_stop_busy", {31'd0, bus.busy}, 32'd0);
      check("rg_stop_done", {31'd0, bus.done}, 32'd0);
      step(3);

      // Repeat without gap: continuous 4/4 square wave across bursts.
      do_start(2, 1, 1, 0, 1'b1);
      step(7);
      check("rn_led_7", {31'd0, bus.led}, 32'd1);
      step(8);
      check("rn_led_15", {31'd0, bus.led}, 32'd1);
      step(1);
      check("rn_led_16", {31'd0, bus.led}, 32'd0);
      step(20);
      bus.stop = 1'b1;
      step(1);
      bus.stop = 1'b0;
      step(3);

      // Async reset mid-OFF.
      do_start(2, 3, 2, 0, 1'b0);
      step(14);
      #3 rst_n = 1'b0;
      #1;
      check("arst_led", {31'd0, bus.led}, 32'd1);
      check("arst_busy", {31'd0, bus.busy}, 32'd0);
      check("arst_done", {31'd0, bus.done}, 32'd0);
      step(2);
      rst_n = 1'b1;
      step(10);
      check("arst_idle_busy", {31'd0, bus.busy}, 32'd0);
      check("arst_idle_led", {31'd0, bus.led}, 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/led_blink_sequencer.md
Name: led_blink_sequencer

Overview:
- Programmable blink-burst controller that sequences the LED timebase divider.
- Owns a shared prescaler (Clk50M → tick) and a per-phase tick counter. Runs an FSM that drives the LED through N on/off blinks, an optional inter-burst gap, and optional continuous repeat.
- Sits between the board control/config logic (start/stop, pattern registers) and the LED pin. Replaces fixed-period toggling with a start/busy/done handshake.

Parameters:
- TICK_DIV, 25_000, Clk50M cycles per tick (0.5 ms at 50 MHz); must be ≥2.
- DIV_W, 25, prescaler counter width; must hold TICK_DIV-1.
- NUM_W, 4, width of blink_num and of the internal blink counter.
- PH_W, 8, width of on_ticks, off_ticks and gap_ticks.

Ports:
- Clk50M  in  1  system clock, 50 MHz
- Rst_n  in  1  reset, asynchronous, active-low
- start  in  1  single-cycle request to begin a burst; sampled only in IDLE
- stop  in  1  abort request; any state returns to IDLE next edge
- blink_num  in  NUM_W  blinks per burst, 1..2^NUM_W-1
- on_ticks  in  PH_W  LED-lit duration in ticks, 1..255
- off_ticks  in  PH_W  LED-dark duration between blinks, 1..255
- gap_ticks  in  PH_W  dark pause after a burst when repeating; 0 = no gap
- repeat  in  1  1 = restart the burst indefinitely until stop
- led  out  1  LED drive, active-low (0 = lit, 1 = dark)
- busy  out  1  high from the edge accepting start until return to IDLE
- done  out  1  one-cycle pulse on normal (non-repeat) burst completion

Behaviour:
- All outputs registered. Reset values: led=1, busy=0, done=0, state=IDLE, all counters 0.
- Prescaler:
  - Counts 0..TICK_DIV-1 and wraps.
  - tick = (div_cnt == TICK_DIV-1).
  - Held at 0 in IDLE; cleared on the accepting edge, so every phase lasts exactly ticks×TICK_DIV cycles.
- Config latch: blink_num, on_ticks, off_ticks, gap_ticks and repeat are latched on start acceptance. Input changes while busy have no effect.
- Start acceptance:
  - Requires state IDLE, start=1, stop=0, blink_num≠0, on_ticks≠0, off_ticks≠0.
  - An invalid start is ignored: no busy, no done.
- State IDLE: led=1, busy=0. On acceptance → ON (led=0, busy=1 from the next edge); phase_cnt=0, blink_cnt=0.
- State ON: led=0. On tick, phase_cnt++. On the tick where phase_cnt==on_ticks-1 → OFF, phase_cnt=0.
- State OFF: led=1. On the tick where phase_cnt==off_ticks-1, blink_cnt++ and:
  - blink_cnt+1 < blink_num → ON.
  - Burst complete, repeat=0 → IDLE; done=1 for that one cycle; busy=0 on the same edge.
  - Burst complete, repeat=1, gap_ticks≠0 → GAP.
  - Burst complete, repeat=1, gap_ticks=0 → ON.
  - Entering ON or GAP at burst end clears blink_cnt.
- State GAP: led=1. On the tick where phase_cnt==gap_ticks-1 → ON, phase_cnt=0.
- stop:
  - Highest priority. From ON/OFF/GAP → IDLE on the next edge: led=1, busy=0, counters cleared, done NOT pulsed.
  - stop in IDLE is a no-op and blocks a same-cycle start.
- start while busy is ignored; it is not queued.
- Latency: start edge to led=0 is 1 cycle. Final OFF tick to done/busy fall is 1 cycle (same edge as the state change).
- Reset mid-burst: immediate return to reset values; no done.
- Counters never overflow: compares are exact-equality against latched values ≥1.

Test Plan:
- Normal burst:
  - Setup: TICK_DIV=4; start with blink_num=2, on=3, off=2, repeat=0.
  - Required: led low 12 cycles, high 8, low 12, high 8.
  - done pulses exactly once, 40 cycles after the accepting edge; busy high for exactly those 40 cycles; led stays 1 afterwards.
- Repeat with gap:
  - Setup: blink_num=1, on=1, off=1, gap=2, repeat=1.
  - Required: led pattern low 4 / high 4 / high 8 (12 dark total) repeating; done never asserts.
  - stop mid-ON → led=1, busy=0 next cycle, no done.
- Repeat without gap:
  - Setup: gap=0, repeat=1, blink_num=2, on=1, off=1.
  - Required: continuous 4-low/4-high square wave with no extra dark period between bursts.
- Invalid / ignored requests:
  - start with blink_num=0, or on_ticks=0 → busy stays 0, led stays 1.
  - start asserted while busy → burst timing unchanged.
  - start and stop in the same IDLE cycle → not accepted.
- Config stability:
  - Change on_ticks from 3 to 7 mid-burst → current burst keeps 3-tick ON phases.
  - Next start uses 7.
- Async reset:
  - Assert Rst_n=0 mid-OFF, asynchronous to Clk50M → led=1, busy=0, done=0 immediately.
  - After release, no activity until a new start.
